// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte FIFO feeding an 8N1, LSB-first UART transmitter.
// Frames run back-to-back while the FIFO holds data.

module uart_tx_serializer #(
    parameter int CLK_DIV    = 521,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             flush,
    output logic             uart_txd,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0]        BAUD_LAST  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    state_t             state;
    state_t             state_d;
    logic [15:0]        baud_cnt;
    logic [15:0]        baud_d;
    logic [2:0]         bit_cnt;
    logic [2:0]         bit_d;
    logic [7:0]         shift;
    logic [7:0]         shift_d;
    logic               txd_d;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               bit_end;

    assign tx_ready   = (fifo_level != LEVEL_FULL) && !flush;
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_level == '0);
    assign bit_end    = (baud_cnt == BAUD_LAST);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    // chain straight into the next start bit: no idle gap
                    if (!fifo_empty && !flush) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            uart_txd <= txd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LEVEL_ONE;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LEVEL_ONE;
            end
        end
    end

endmodule
